flappy_game_ctrl: RTL and testbench
===================================

# flappy_game_ctrl

Game-sequencing controller for Flappy Bird. It owns the play state (waiting, flying, dead), the bird's vertical physics, two scrolling pipes with pseudo-random gaps, collision detection and the score. It advances once per video frame and sits between the keypad/switch front end and the VGA display and seven-segment score path, which consume its registered outputs.

## Interface
Parameters:
- `BIRD_X`, default 160: fixed left edge of the bird in pixels; bird is 16×16.
- `GROUND_Y`, default 440: floor line; bird bottom must stay below it.
- `PIPE_W`, default 48: pipe width in pixels.
- `GAP_H`, default 120: vertical gap height in pixels.
- `PIPE_SPD`, default 2: pipe scroll in pixels per frame; must be even.
- `FLAP_V`, default -6: velocity loaded on a flap (signed).
- `VMAX`, default 8: terminal fall velocity.

Ports (reset is asynchronous, active-low; one clock):
- `clk` input 1: system clock.
- `rstn` input 1: asynchronous active-low reset.
- `frame_tick` input 1: one-cycle pulse per frame (vsync edge).
- `flap` input 1: one-cycle pulse from the keypad.
- `invincible` input 1: level from a debounced switch; disables pipe collision only.
- `state` output 2: 0 IDLE, 1 FLY, 2 DEAD (3 unused).
- `score` output 8: pipes passed, saturating.
- `bird_y` output 10: bird top edge.
- `pipe0_x`, `pipe1_x` output 10 each: pipe left edges.
- `pipe0_gap`, `pipe1_gap` output 9 each: gap top edges.

## Operation
- Reset values: state=0, score=0, bird_y=232, velocity=0, pipe0_x=640, pipe1_x=960, pipe0_gap=pipe1_gap=180, flap_pend=0, LFSR=8'hA5.
- `flap_pend` is set by `flap` and cleared on each `frame_tick`. A `flap` in the same cycle as a tick counts for that tick. Several flaps between ticks count as one.
- The LFSR free-runs every clk with polynomial x^8+x^6+x^5+x^4+1. A new gap is loaded as 60 + LFSR, giving a range of 60..315.
- IDLE, on each tick:
  - With a flap: go to FLY, velocity=FLAP_V, score=0, no movement this tick.
  - Without a flap: nothing changes.
- FLY, on each tick, compute the next values first:
  - y' = bird_y + vel, in signed 11-bit arithmetic.
  - vel' = FLAP_V if a flap is pending, else min(vel+1, VMAX). The velocity register is 5-bit signed.
  - Each pipe: if x==0, then x'=640 and a new gap is loaded; else x'=x−PIPE_SPD.
- FLY death conditions:
  - y' < 0: clamp bird_y=0 and go to DEAD.
  - y'+16 ≥ GROUND_Y: clamp bird_y=GROUND_Y−16 and go to DEAD.
  - Pipe hit (skipped when `invincible`=1): BIRD_X+16 > x' and BIRD_X < x'+PIPE_W, and (y' < gap or y'+16 > gap+GAP_H), for either pipe. Go to DEAD; positions take the computed next values.
- FLY scoring: when there is no death this tick, score increments for each pipe with x' == BIRD_X−PIPE_W (112 at defaults). Score saturates at 255.
- DEAD: all positions are frozen. A tick with a flap goes to IDLE and reloads the reset positions and gaps (gaps from the LFSR). Score is held until the next IDLE→FLY transition.
- `rstn` low at any time, including mid-frame: all registers return to their reset values immediately.

## Timing
- All outputs are registered and update on the clock edge of the `frame_tick` cycle. They are stable for the remainder of the frame.
- Latency: a flap pulse affects motion on the first tick at or after it. The resulting position is visible one cycle after that tick.
- No combinational path from inputs to outputs.

## Structure
- Shared header `flappy_defs.vh` holds:
  - State encodings ST_IDLE, ST_FLY, ST_DEAD.
  - Screen constants: H=640, V=480.
  - Start positions: bird 232, pipes 640/960.
  - Gap base 60.
- One sub-module: `lfsr8` (clk, rstn, q[7:0]).
- The rest is one FSM plus next-state datapath in `flappy_game_ctrl`, roughly 200 lines.

## Test plan
- Reset then 10 ticks with no flap → state=0, bird_y=232, pipe0_x=640, pipe1_x=960, score=0. Assert `rstn` mid-FLY → same values in the same cycle.
- Flap then 1 tick → state=1, bird_y=232. Next tick with no flap → bird_y=226. Following tick → bird_y=221.
- In FLY, flap pending every tick → bird_y=232−6n. On FLY tick 39: state=2, bird_y=0.
- One flap then none → within 60 ticks state=2, bird_y=424, score=0. A further 5 ticks → outputs frozen.
- `invincible`=1, bench flaps whenever bird_y>300:
  - Score reaches 1 on FLY tick 264 and 2 on tick 424.
  - pipe0_x goes from 0 to 640 on tick 321, and pipe0_gap is in 60..315.
- Flap and `frame_tick` in the same cycle in DEAD → state=0 next cycle, positions reloaded. Two flaps between ticks → velocity −6 once.

Source files
------------

// File: rtl/flappy_game_ctrl_pkg.sv
// Shared state encodings and start-up constants for the Flappy Bird game controller.
package flappy_game_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FLY  = 2'd1,
        ST_DEAD = 2'd2
    } game_state_t;

    localparam int SCREEN_H    = 640;
    localparam int BIRD_START  = 232;
    localparam int PIPE0_START = 640;
    localparam int PIPE1_START = 960;
    localparam int GAP_BASE    = 60;
    localparam int GAP_RESET   = 180;

    localparam logic [7:0] LFSR_SEED = 8'hA5;

    // Fresh gaps land in 60..315 so the opening always stays on screen.
    function automatic logic [8:0] gap_from_lfsr(input logic [7:0] r);
        return 9'(GAP_BASE) + {1'b0, r};
    endfunction

endpackage

// File: rtl/flappy_game_ctrl_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) used to pick pipe gaps.
module lfsr8
    import flappy_game_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    output logic [7:0] q
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q <= LFSR_SEED;
        end else begin
            q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
        end
    end

endmodule

// File: rtl/flappy_game_ctrl.sv
// Frame-stepped Flappy Bird sequencer: play state, bird physics, two scrolling pipes,
// collision detection and a saturating score, all held in registers.
module flappy_game_ctrl
    import flappy_game_ctrl_pkg::*;
#(
    parameter int BIRD_X   = 160,
    parameter int GROUND_Y = 440,
    parameter int PIPE_W   = 48,
    parameter int GAP_H    = 120,
    parameter int PIPE_SPD = 2,
    parameter int FLAP_V   = -6,
    parameter int VMAX     = 8
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       frame_tick,
    input  logic       flap,
    input  logic       invincible,
    output logic [1:0] state,
    output logic [7:0] score,
    output logic [9:0] bird_y,
    output logic [9:0] pipe0_x,
    output logic [9:0] pipe1_x,
    output logic [8:0] pipe0_gap,
    output logic [8:0] pipe1_gap
);

    localparam logic signed [4:0]  FLAP_VEL  = 5'(FLAP_V);
    localparam logic signed [4:0]  VEL_MAX   = 5'(VMAX);
    localparam logic signed [10:0] FLOOR_TOP = 11'(GROUND_Y - 16);
    localparam logic [9:0]         SCORE_X   = 10'(BIRD_X - PIPE_W);
    localparam logic [9:0]         SPD       = 10'(PIPE_SPD);

    game_state_t       st;
    logic signed [4:0] vel;
    logic              flap_pend;
    logic [7:0]        lfsr_q;

    logic               flap_now;
    logic signed [10:0] y_next;
    logic signed [4:0]  vel_next;
    logic [9:0]         x0_next, x1_next, y_fly;
    logic [8:0]         g0_next, g1_next;
    logic               ceil_hit, floor_hit, pipe_any, died;
    logic [1:0]         passes;
    logic [8:0]         score_sum;
    logic [7:0]         score_next;

    lfsr8 u_lfsr (
        .clk  (clk),
        .rstn (rstn),
        .q    (lfsr_q)
    );

    assign state = st;

    // Overlap test of the 16x16 bird against one pipe, outside its gap.
    function automatic logic pipe_hit(input logic [9:0] x, input logic [8:0] gap,
                                      input logic signed [10:0] y);
        int xi, gi, yi;
        xi = int'(x);
        gi = int'(gap);
        yi = int'(y);
        return (BIRD_X + 16 > xi) && (BIRD_X < xi + PIPE_W) &&
               ((yi < gi) || (yi + 16 > gi + GAP_H));
    endfunction

    always_comb begin
        flap_now = flap | flap_pend;
        y_next   = $signed({1'b0, bird_y}) + 11'(vel);

        if (flap_now)             vel_next = FLAP_VEL;
        else if (vel >= VEL_MAX)  vel_next = VEL_MAX;
        else                      vel_next = vel + 5'sd1;

        x0_next = (pipe0_x == '0) ? 10'(SCREEN_H) : pipe0_x - SPD;
        x1_next = (pipe1_x == '0) ? 10'(SCREEN_H) : pipe1_x - SPD;
        g0_next = (pipe0_x == '0) ? gap_from_lfsr(lfsr_q) : pipe0_gap;
        g1_next = (pipe1_x == '0) ? gap_from_lfsr(lfsr_q) : pipe1_gap;

        ceil_hit  = y_next[10];
        floor_hit = y_next >= FLOOR_TOP;
        pipe_any  = !invincible && (pipe_hit(x0_next, g0_next, y_next) ||
                                    pipe_hit(x1_next, g1_next, y_next));
        died      = ceil_hit | floor_hit | pipe_any;

        if (ceil_hit)       y_fly = '0;
        else if (floor_hit) y_fly = 10'(GROUND_Y - 16);
        else                y_fly = y_next[9:0];

        passes     = {1'b0, (x0_next == SCORE_X)} + {1'b0, (x1_next == SCORE_X)};
        score_sum  = {1'b0, score} + {7'b0, passes};
        score_next = score_sum[8] ? 8'hFF : score_sum[7:0];
    end

    // Everything advances only on frame ticks; flaps between ticks are latched.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st        <= ST_IDLE;
            score     <= '0;
            bird_y    <= 10'(BIRD_START);
            vel       <= '0;
            pipe0_x   <= 10'(PIPE0_START);
            pipe1_x   <= 10'(PIPE1_START);
            pipe0_gap <= 9'(GAP_RESET);
            pipe1_gap <= 9'(GAP_RESET);
            flap_pend <= 1'b0;
        end else if (frame_tick) begin
            flap_pend <= 1'b0;
            case (st)
                ST_IDLE: begin
                    if (flap_now) begin
                        st    <= ST_FLY;
                        vel   <= FLAP_VEL;
                        score <= '0;
                    end
                end
                ST_FLY: begin
                    vel       <= vel_next;
                    bird_y    <= y_fly;
                    pipe0_x   <= x0_next;
                    pipe1_x   <= x1_next;
                    pipe0_gap <= g0_next;
                    pipe1_gap <= g1_next;
                    if (died) st <= ST_DEAD;
                    else      score <= score_next;
                end
                ST_DEAD: begin
                    if (flap_now) begin
                        st        <= ST_IDLE;
                        vel       <= '0;
                        bird_y    <= 10'(BIRD_START);
                        pipe0_x   <= 10'(PIPE0_START);
                        pipe1_x   <= 10'(PIPE1_START);
                        pipe0_gap <= gap_from_lfsr(lfsr_q);
                        pipe1_gap <= gap_from_lfsr(lfsr_q);
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end else if (flap) begin
            flap_pend <= 1'b1;
        end
    end

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Self-checking bench for flappy_game_ctrl: game-rule model compared every cycle,
// directed literal scenarios, then randomized play with occasional async resets.
module tb_flappy_game_ctrl;

    logic       clk = 1'b0;
    logic       rstn, frame_tick, flap, invincible;
    logic [1:0] state;
    logic [7:0] score;
    logic [9:0] bird_y, pipe0_x, pipe1_x;
    logic [8:0] pipe0_gap, pipe1_gap;

    int n_compared   = 0;
    int n_mismatched = 0;
    bit cmp_en       = 1'b0;

    int m_state, m_score, m_y, m_vel, m_lfsr;
    int m_x[2];
    int m_gap[2];
    bit m_pend;

    flappy_game_ctrl dut (
        .clk        (clk),
        .rstn       (rstn),
        .frame_tick (frame_tick),
        .flap       (flap),
        .invincible (invincible),
        .state      (state),
        .score      (score),
        .bird_y     (bird_y),
        .pipe0_x    (pipe0_x),
        .pipe1_x    (pipe1_x),
        .pipe0_gap  (pipe0_gap),
        .pipe1_gap  (pipe1_gap)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_compared++;
        if (actual != expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    function automatic int lfsrNext(input int r);
        int fb;
        fb = ((r >> 7) ^ (r >> 5) ^ (r >> 4) ^ (r >> 3)) & 1;
        return ((r << 1) | fb) & 255;
    endfunction

    task automatic modelReset();
        m_state = 0; m_score = 0; m_y = 232; m_vel = 0; m_pend = 1'b0;
        m_x[0] = 640; m_x[1] = 960; m_gap[0] = 180; m_gap[1] = 180;
        m_lfsr = 8'hA5;
    endtask

    // Game rules applied to one clock edge with the inputs seen at that edge.
    task automatic modelStep(input bit tick, input bit fl);
        int ny, nv;
        int nx[2];
        int ng[2];
        bit eff, dead;
        if (!rstn) return;
        eff = fl || m_pend;
        if (tick) begin
            if (m_state == 0) begin
                if (eff) begin m_state = 1; m_vel = -6; m_score = 0; end
            end else if (m_state == 1) begin
                ny = m_y + m_vel;
                nv = eff ? -6 : ((m_vel + 1 > 8) ? 8 : m_vel + 1);
                for (int p = 0; p < 2; p++) begin
                    nx[p] = (m_x[p] == 0) ? 640 : m_x[p] - 2;
                    ng[p] = (m_x[p] == 0) ? 60 + m_lfsr : m_gap[p];
                end
                dead = 1'b0;
                if (ny < 0) begin ny = 0; dead = 1'b1; end
                else if (ny + 16 >= 440) begin ny = 424; dead = 1'b1; end
                else if (!invincible) begin
                    for (int p = 0; p < 2; p++)
                        if (176 > nx[p] && 160 < nx[p] + 48 &&
                            (ny < ng[p] || ny + 16 > ng[p] + 120)) dead = 1'b1;
                end
                if (!dead)
                    for (int p = 0; p < 2; p++)
                        if (nx[p] == 112 && m_score < 255) m_score++;
                m_y = ny; m_vel = nv; m_x = nx; m_gap = ng;
                if (dead) m_state = 2;
            end else if (eff) begin
                m_state = 0; m_y = 232; m_x[0] = 640; m_x[1] = 960;
                m_gap[0] = 60 + m_lfsr; m_gap[1] = 60 + m_lfsr;
            end
            m_pend = 1'b0;
        end else if (fl) begin
            m_pend = 1'b1;
        end
        m_lfsr = lfsrNext(m_lfsr);
    endtask

    task automatic applyStimulus(input bit tick, input bit fl);
        @(negedge clk);
        frame_tick = tick;
        flap       = fl;
        @(posedge clk);
        modelStep(tick, fl);
    endtask

    task automatic releaseReset();
        @(negedge clk);
        rstn = 1'b1; frame_tick = 1'b0; flap = 1'b0;
        @(posedge clk);
        modelStep(1'b0, 1'b0);
    endtask

    // One frame: optional flap early in the frame, tick on the third cycle.
    task automatic frame(input bit fl);
        applyStimulus(1'b0, fl);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
    endtask

    task automatic expectLit(input string tag, input int st, input int y,
                             input int x0, input int x1, input int sc);
        checkOutput({tag, "_state"}, state, st);
        checkOutput({tag, "_bird_y"}, bird_y, y);
        checkOutput({tag, "_pipe0_x"}, pipe0_x, x0);
        checkOutput({tag, "_pipe1_x"}, pipe1_x, x1);
        checkOutput({tag, "_score"}, score, sc);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            checkOutput("model_state", state, m_state);
            checkOutput("model_score", score, m_score);
            checkOutput("model_bird_y", bird_y, m_y);
            checkOutput("model_pipe0_x", pipe0_x, m_x[0]);
            checkOutput("model_pipe1_x", pipe1_x, m_x[1]);
            checkOutput("model_pipe0_gap", pipe0_gap, m_gap[0]);
            checkOutput("model_pipe1_gap", pipe1_gap, m_gap[1]);
        end
    end

    initial begin
        bit fell;
        rstn = 1'b0; frame_tick = 1'b0; flap = 1'b0; invincible = 1'b0;
        modelReset();
        cmp_en = 1'b1;
        repeat (3) applyStimulus(1'b0, 1'b0);
        #1 expectLit("reset", 0, 232, 640, 960, 0);
        releaseReset();

        repeat (10) frame(1'b0);
        #1 expectLit("idle10", 0, 232, 640, 960, 0);
        checkOutput("idle10_gap0", pipe0_gap, 180);

        frame(1'b1);
        #1 expectLit("takeoff", 1, 232, 640, 960, 0);
        frame(1'b0);
        #1 checkOutput("fly_y1", bird_y, 226);
        frame(1'b0);
        #1 checkOutput("fly_y2", bird_y, 221);
        checkOutput("fly_x0_2", pipe0_x, 636);

        #1 rstn = 1'b0;
        modelReset();
        #1 expectLit("midreset", 0, 232, 640, 960, 0);
        applyStimulus(1'b0, 1'b0);
        releaseReset();

        frame(1'b1);
        #1 checkOutput("climb_start", state, 1);
        for (int n = 1; n <= 39; n++) begin
            frame(1'b1);
            #1;
            if (n < 39) begin
                checkOutput($sformatf("climb_y%0d", n), bird_y, 232 - 6 * n);
            end else begin
                checkOutput("ceiling_state", state, 2);
                checkOutput("ceiling_y", bird_y, 0);
            end
        end

        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1);
        #1 expectLit("restart", 0, 232, 640, 960, 0);

        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0);
        #1 checkOutput("twoflap_state", state, 1);
        frame(1'b0);
        #1 checkOutput("twoflap_y1", bird_y, 226);
        frame(1'b0);
        #1 checkOutput("twoflap_y2", bird_y, 221);

        fell = 1'b0;
        for (int k = 0; k < 60 && !fell; k++) begin
            frame(1'b0);
            #1 if (state == 2'd2) fell = 1'b1;
        end
        checkOutput("floor_reached", int'(fell), 1);
        expectLit("floor", 2, 424, 564, 884, 0);
        repeat (5) frame(1'b0);
        #1 expectLit("frozen", 2, 424, 564, 884, 0);

        frame(1'b1);
        invincible = 1'b1;
        frame(1'b1);
        #1 expectLit("inv_start", 1, 232, 640, 960, 0);
        for (int n = 1; n <= 430; n++) begin
            frame(m_y > 300);
            #1;
            if (n == 263) checkOutput("inv_score_263", score, 0);
            if (n == 264) checkOutput("inv_score_264", score, 1);
            if (n == 320) checkOutput("inv_x0_320", pipe0_x, 0);
            if (n == 321) begin
                checkOutput("inv_x0_321", pipe0_x, 640);
                checkOutput("inv_gap_range", int'(pipe0_gap >= 9'd60 && pipe0_gap <= 9'd315), 1);
            end
            if (n == 424) checkOutput("inv_score_424", score, 2);
        end
        checkOutput("inv_alive", state, 1);

        invincible = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (($urandom % 97) == 0) invincible = ~invincible;
            applyStimulus(($urandom % 3) == 0,
                          (($urandom % 8) == 0) ||
                          (m_state == 1 && m_y > 280 && ($urandom % 2) == 0));
            if (($urandom % 700) == 0) begin
                #2 rstn = 1'b0;
                modelReset();
                applyStimulus(1'b0, 1'b0);
                releaseReset();
            end
        end

        @(negedge clk);
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
